// File: rtl/vid_dma_pkg.sv
// Shared definitions for the video DMA fetch engine.
//   state_t     : fetch FSM states (IDLE, BURST, FLUSH)
//   CTI_*       : wishbone cycle type identifiers driven on wb_cti
//   BURST_LEN   : beats per line fetch (one 16-byte line = 4 x 32-bit words)
package vid_dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    localparam int BURST_LEN = 4;

endpackage

// File: rtl/vid_fifo.sv
// First-word-fall-through word FIFO feeding the video output stage.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   flush          : synchronous clear of contents and underflow flag (wins over wr/rd)
//   wr, wr_data    : push one word
//   rd             : pop the head word (ignored when empty, sets underflow)
//   rd_data        : head word, valid when !empty; holds its last value when empty
//   empty, level   : occupancy status
//   underflow      : sticky, set by rd on an empty FIFO
module vid_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       wr,
    input  logic [31:0]                wr_data,
    input  logic                       rd,
    output logic [31:0]                rd_data,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   level_reg;
    logic [31:0]   dat_reg;
    logic          uf_reg;

    logic          pop;
    logic          push;
    logic [AW-1:0] rd_ptr_next;
    logic [AW:0]   level_after_pop;
    logic [AW:0]   level_next;

    assign pop  = rd && (level_reg != '0);
    assign push = wr && ((level_reg != FULL) || pop);

    always_comb begin
        rd_ptr_next     = rd_ptr_reg + AW'(pop);
        level_after_pop = level_reg - (AW+1)'(pop);
        level_next      = level_after_pop + (AW+1)'(push);
    end

    // Storage array without reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            dat_reg    <= '0;
            uf_reg     <= 1'b0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            uf_reg     <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + AW'(push);
            rd_ptr_reg <= rd_ptr_next;
            level_reg  <= level_next;
            if (rd && (level_reg == '0)) begin
                uf_reg <= 1'b1;
            end
            // Head register: when the only remaining word is the one being
            // written now, take it straight from the write port; otherwise
            // the next head is already in the array. Hold when going empty.
            if (level_next != '0) begin
                dat_reg <= (push && (level_after_pop == '0)) ? wr_data : mem[rd_ptr_next];
            end
        end
    end

    assign rd_data   = dat_reg;
    assign empty     = (level_reg == '0);
    assign level     = level_reg;
    assign underflow = uf_reg;

endmodule

// File: rtl/vid_dma_fetch.sv
// Wishbone burst-read master streaming a circular line buffer from SDRAM
// into a local FWFT word FIFO.
// Ports:
//   wb_clk, wb_rst_n          : clock, asynchronous active-low reset
//   dma_en                    : allow new bursts to start
//   frame_sync                : restart at vinit, flush FIFO, clear underflow
//   vinit, vstart, vend       : line pointers (byte address [23:4])
//   wb_adr/cti/sel/we/stb/cyc : registered wishbone master outputs
//   wb_ack, wb_dat_i          : wishbone slave response
//   vid_rd, vid_dat, vid_empty, fifo_level, underflow : video-side FIFO port
module vid_dma_fetch
    import vid_dma_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          wb_clk,
    input  logic                          wb_rst_n,
    input  logic                          dma_en,
    input  logic                          frame_sync,
    input  logic [19:0]                   vinit,
    input  logic [19:0]                   vstart,
    input  logic [19:0]                   vend,
    output logic [23:0]                   wb_adr,
    output logic [2:0]                    wb_cti,
    output logic [3:0]                    wb_sel,
    output logic                          wb_we,
    output logic                          wb_stb,
    output logic                          wb_cyc,
    input  logic                          wb_ack,
    input  logic [31:0]                   wb_dat_i,
    input  logic                          vid_rd,
    output logic [31:0]                   vid_dat,
    output logic                          vid_empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underflow
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    // Launch only if a whole burst still fits: space is reserved up front.
    localparam logic [LW-1:0] LAUNCH_MAX = LW'(FIFO_DEPTH - BURST_LEN);

    state_t      state_reg, state_next;
    logic [19:0] ptr_reg,   ptr_next;
    logic [1:0]  beat_reg,  beat_next;
    logic        stb_reg,   stb_next;
    logic [23:0] adr_reg,   adr_next;
    logic [2:0]  cti_reg,   cti_next;
    logic        fifo_wr;
    logic        last_beat;

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        beat_next  = beat_reg;
        stb_next   = stb_reg;
        adr_next   = adr_reg;
        cti_next   = cti_reg;
        fifo_wr    = 1'b0;
        last_beat  = wb_ack && (beat_reg == 2'(BURST_LEN - 1));

        case (state_reg)
            IDLE: begin
                if (frame_sync) begin
                    ptr_next = vinit;
                end else if (dma_en && (fifo_level <= LAUNCH_MAX)) begin
                    state_next = BURST;
                    stb_next   = 1'b1;
                    adr_next   = {ptr_reg, 4'h0};
                    beat_next  = 2'd0;
                    cti_next   = CTI_INCR;
                end
            end
            BURST, FLUSH: begin
                if (wb_ack) begin
                    beat_next = beat_reg + 2'd1;
                    if (beat_reg == 2'(BURST_LEN - 2)) begin
                        cti_next = CTI_END;
                    end
                end
                // Beats are kept only in BURST and only if no sync arrives now.
                fifo_wr = (state_reg == BURST) && wb_ack && !frame_sync;
                if (last_beat) begin
                    state_next = IDLE;
                    stb_next   = 1'b0;
                    cti_next   = CTI_CLASSIC;
                    if ((state_reg == BURST) && !frame_sync) begin
                        ptr_next = (ptr_reg == vend) ? vstart : ptr_reg + 20'd1;
                    end
                end
                // A sync mid-burst cannot abort the controller's burst; the
                // remaining beats are drained in FLUSH and thrown away.
                if (frame_sync) begin
                    ptr_next = vinit;
                    if (!last_beat) begin
                        state_next = FLUSH;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                stb_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            beat_reg  <= '0;
            stb_reg   <= 1'b0;
            adr_reg   <= '0;
            cti_reg   <= CTI_CLASSIC;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            beat_reg  <= beat_next;
            stb_reg   <= stb_next;
            adr_reg   <= adr_next;
            cti_reg   <= cti_next;
        end
    end

    assign wb_adr = adr_reg;
    assign wb_cti = cti_reg;
    assign wb_sel = 4'hF;
    assign wb_we  = 1'b0;
    assign wb_stb = stb_reg;
    assign wb_cyc = stb_reg;

    vid_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (wb_clk),
        .rst_n     (wb_rst_n),
        .flush     (frame_sync),
        .wr        (fifo_wr),
        .wr_data   (wb_dat_i),
        .rd        (vid_rd),
        .rd_data   (vid_dat),
        .empty     (vid_empty),
        .level     (fifo_level),
        .underflow (underflow)
    );

endmodule
